// File: rtl/sw_pkg.sv
// Shared types and constants for the Smith-Waterman affine-gap array.
// Optional feature macro: SW_POS_TRACK_EN (best-cell row/col tagging).
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [1:0] base_t;

  localparam base_t BASE_A = 2'd0;
  localparam base_t BASE_C = 2'd1;
  localparam base_t BASE_G = 2'd2;
  localparam base_t BASE_T = 2'd3;

  // Default scoring set used by the benches.
  localparam int DEF_MATCH    = 8;
  localparam int DEF_MISMATCH = -5;
  localparam int DEF_GAP_OPEN = -7;
  localparam int DEF_GAP_EXT  = -3;

endpackage

// File: rtl/sw_affine_array_if.sv
// Beat/result handshake bundle for sw_affine_array.
// Optional feature macro: SW_POS_TRACK_EN adds out_row/out_col.
interface sw_affine_array_if #(
  parameter int PE_NUM  = 256,
  parameter int SCORE_W = 12
);
  localparam int POS_W = $clog2(PE_NUM);

  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                data_s;
  logic [1:0]                data_t;
  logic signed [SCORE_W-1:0] cfg_match;
  logic signed [SCORE_W-1:0] cfg_mismatch;
  logic signed [SCORE_W-1:0] cfg_gap_open;
  logic signed [SCORE_W-1:0] cfg_gap_ext;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [SCORE_W-1:0] max;
`ifdef SW_POS_TRACK_EN
  logic [POS_W-1:0]          out_row;
  logic [POS_W-1:0]          out_col;
`endif

  modport master (
    output in_valid, data_s, data_t, cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext, out_ready,
    input  in_ready, out_valid, max
`ifdef SW_POS_TRACK_EN
    , out_row, out_col
`endif
  );

  modport slave (
    input  in_valid, data_s, data_t, cfg_match, cfg_mismatch, cfg_gap_open, cfg_gap_ext, out_ready,
    output in_ready, out_valid, max
`ifdef SW_POS_TRACK_EN
    , out_row, out_col
`endif
  );

endinterface

// File: rtl/sw_pe.sv
// One systolic cell: holds a query base, pipelines target bases and
// evaluates the affine-gap recurrence plus the chained running max.
// Optional feature macro: SW_POS_TRACK_EN (row/col tag on the max).
module sw_pe
  import sw_pkg::*;
#(
  parameter int SCORE_W = 12
`ifdef SW_POS_TRACK_EN
  , parameter int POS_W = 2
  , parameter int ROW   = 0
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      en_in,
  input  logic                      s_load,
  input  base_t                     s_in,
  input  base_t                     t_in,
  input  logic signed [SCORE_W-1:0] v_up,
  input  logic signed [SCORE_W-1:0] f_up,
  input  logic signed [SCORE_W-1:0] max_in,
  input  logic signed [SCORE_W-1:0] cfg_match,
  input  logic signed [SCORE_W-1:0] cfg_mismatch,
  input  logic signed [SCORE_W-1:0] cfg_gap_open,
  input  logic signed [SCORE_W-1:0] cfg_gap_ext,
`ifdef SW_POS_TRACK_EN
  input  logic [POS_W-1:0]          row_in,
  input  logic [POS_W-1:0]          col_in,
  output logic [POS_W-1:0]          row_out,
  output logic [POS_W-1:0]          col_out,
`endif
  output logic                      en_out,
  output base_t                     t_out,
  output logic signed [SCORE_W-1:0] v_out,
  output logic signed [SCORE_W-1:0] f_out,
  output logic signed [SCORE_W-1:0] max_out
);

  typedef logic signed [SCORE_W-1:0] score_t;
`ifdef SW_POS_TRACK_EN
  typedef logic [POS_W-1:0] pos_t;
  localparam pos_t ROW_IDX = pos_t'(ROW);
`endif

  typedef struct packed {
    base_t  s;
    base_t  t;
    logic   en;
    score_t vdiag;
    score_t v;
    score_t e;
    score_t f;
    score_t mx;
`ifdef SW_POS_TRACK_EN
    pos_t   row;
    pos_t   col;
    pos_t   k;
`endif
  } pe_t;

  pe_t    r;
  base_t  s_eff;
  score_t e_new, f_new, diag, v_new, mx_new;
`ifdef SW_POS_TRACK_EN
  pos_t   row_new, col_new;
`endif

  function automatic score_t smax(score_t a, score_t b);
    return (a >= b) ? a : b;
  endfunction

`ifdef SW_POS_TRACK_EN
  function automatic logic wins(score_t a, pos_t ar, pos_t ac, score_t b, pos_t br, pos_t bc);
    return (a > b) || ((a == b) && ((ar < br) || ((ar == br) && (ac < bc))));
  endfunction
`endif

  // Cell recurrence; the query base is bypassed on the cycle it is latched.
  always_comb begin
    s_eff  = s_load ? s_in : r.s;
    e_new  = smax(r.e + cfg_gap_ext, r.v + cfg_gap_open);
    f_new  = smax(f_up + cfg_gap_ext, v_up + cfg_gap_open);
    diag   = r.vdiag + ((s_eff == t_in) ? cfg_match : cfg_mismatch);
    v_new  = smax(smax(smax('0, diag), e_new), f_new);
`ifdef SW_POS_TRACK_EN
    mx_new  = r.mx;
    row_new = r.row;
    col_new = r.col;
    if (wins(max_in, row_in, col_in, mx_new, row_new, col_new)) begin
      mx_new  = max_in;
      row_new = row_in;
      col_new = col_in;
    end
    if (wins(v_new, ROW_IDX, r.k, mx_new, row_new, col_new)) begin
      mx_new  = v_new;
      row_new = ROW_IDX;
      col_new = r.k;
    end
`else
    mx_new = smax(smax(v_new, max_in), r.mx);
`endif
  end

  // Cell state: cleared by reset or job clear, advanced only on valid cells.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
    end else if (clr) begin
      r <= '0;
    end else begin
      r.en <= en_in;
      if (s_load) r.s <= s_in;
      if (en_in) begin
        r.t     <= t_in;
        r.vdiag <= v_up;
        r.v     <= v_new;
        r.e     <= e_new;
        r.f     <= f_new;
        r.mx    <= mx_new;
`ifdef SW_POS_TRACK_EN
        r.row   <= row_new;
        r.col   <= col_new;
        r.k     <= r.k + pos_t'(1);
`endif
      end
    end
  end

  assign en_out  = r.en;
  assign t_out   = r.t;
  assign v_out   = r.v;
  assign f_out   = r.f;
  assign max_out = r.mx;
`ifdef SW_POS_TRACK_EN
  assign row_out = r.row;
  assign col_out = r.col;
`endif

endmodule

// File: rtl/sw_affine_array.sv
// Smith-Waterman local-alignment array with affine gaps: FSM, beat
// counter, configuration latch and result port around PE_NUM cells.
// Optional feature macro: SW_POS_TRACK_EN (best-cell row/col output).
module sw_affine_array
  import sw_pkg::*;
#(
  parameter int PE_NUM  = 256,
  parameter int SCORE_W = 12
) (
  input logic              clk,
  input logic              reset,
  sw_affine_array_if.slave bus
);

  localparam int POS_W = $clog2(PE_NUM);
  typedef logic signed [SCORE_W-1:0] score_t;
  typedef logic [POS_W-1:0]          pos_t;

  state_t state;
  pos_t   cnt;
  score_t match_r, mismatch_r, open_r, ext_r;
  score_t match_e, mismatch_e, open_e, ext_e;
  logic   in_ready_r, out_valid_r;
  logic   accept, clr;
  pos_t   beat_idx;

  logic [PE_NUM:0]  en_c;
  base_t            t_c  [PE_NUM+1];
  score_t           v_c  [PE_NUM+1];
  score_t           f_c  [PE_NUM+1];
  score_t           mx_c [PE_NUM+1];
`ifdef SW_POS_TRACK_EN
  pos_t             row_c[PE_NUM+1];
  pos_t             col_c[PE_NUM+1];
`endif
  logic             unused_tail;

  assign accept   = bus.in_valid && in_ready_r;
  assign clr      = ((state == LOAD) && !bus.in_valid) || ((state == DONE) && bus.out_ready);
  assign beat_idx = (state == LOAD) ? cnt : '0;

  // Cell (0,0) is computed on the beat that latches the config, so it sees the live inputs.
  assign match_e    = (state == IDLE) ? bus.cfg_match    : match_r;
  assign mismatch_e = (state == IDLE) ? bus.cfg_mismatch : mismatch_r;
  assign open_e     = (state == IDLE) ? bus.cfg_gap_open : open_r;
  assign ext_e      = (state == IDLE) ? bus.cfg_gap_ext  : ext_r;

  // Job sequencing: accept PE_NUM beats, drain the wavefront, hold the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      match_r     <= '0;
      mismatch_r  <= '0;
      open_r      <= '0;
      ext_r       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          state      <= LOAD;
          cnt        <= pos_t'(1);
          match_r    <= bus.cfg_match;
          mismatch_r <= bus.cfg_mismatch;
          open_r     <= bus.cfg_gap_open;
          ext_r      <= bus.cfg_gap_ext;
        end
        LOAD: if (!bus.in_valid) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt == pos_t'(PE_NUM - 1)) begin
          state      <= DRAIN;
          cnt        <= '0;
          in_ready_r <= 1'b0;
        end else begin
          cnt <= cnt + pos_t'(1);
        end
        DRAIN: if (cnt == pos_t'(PE_NUM - 2)) begin
          state       <= DONE;
          cnt         <= '0;
          out_valid_r <= 1'b1;
        end else begin
          cnt <= cnt + pos_t'(1);
        end
        DONE: if (bus.out_ready) begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign en_c[0] = accept;
  assign t_c[0]  = bus.data_t;
  assign v_c[0]  = '0;
  assign f_c[0]  = '0;
  assign mx_c[0] = '0;
`ifdef SW_POS_TRACK_EN
  assign row_c[0] = '0;
  assign col_c[0] = '0;
`endif

  for (genvar j = 0; j < PE_NUM; j++) begin : g_pe
    sw_pe #(
      .SCORE_W(SCORE_W)
`ifdef SW_POS_TRACK_EN
      , .POS_W(POS_W)
      , .ROW(j)
`endif
    ) u_pe (
      .clk          (clk),
      .reset        (reset),
      .clr          (clr),
      .en_in        (en_c[j]),
      .s_load       (accept && (beat_idx == pos_t'(j))),
      .s_in         (bus.data_s),
      .t_in         (t_c[j]),
      .v_up         (v_c[j]),
      .f_up         (f_c[j]),
      .max_in       (mx_c[j]),
      .cfg_match    (match_e),
      .cfg_mismatch (mismatch_e),
      .cfg_gap_open (open_e),
      .cfg_gap_ext  (ext_e),
`ifdef SW_POS_TRACK_EN
      .row_in       (row_c[j]),
      .col_in       (col_c[j]),
      .row_out      (row_c[j+1]),
      .col_out      (col_c[j+1]),
`endif
      .en_out       (en_c[j+1]),
      .t_out        (t_c[j+1]),
      .v_out        (v_c[j+1]),
      .f_out        (f_c[j+1]),
      .max_out      (mx_c[j+1])
    );
  end

  assign unused_tail = ^{en_c[PE_NUM], t_c[PE_NUM], v_c[PE_NUM], f_c[PE_NUM]};

  // The last PE's max register is frozen while DONE holds, so gating it is glitch-free.
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.max       = out_valid_r ? mx_c[PE_NUM] : '0;
`ifdef SW_POS_TRACK_EN
  assign bus.out_row   = out_valid_r ? row_c[PE_NUM] : '0;
  assign bus.out_col   = out_valid_r ? col_c[PE_NUM] : '0;
`endif

endmodule

// File: tb/tb_sw_affine_array.sv
// Directed, table-driven bench for sw_affine_array at PE_NUM=4.
// Row/col expectations are checked when SW_POS_TRACK_EN is defined.
module tb_sw_affine_array;
  import sw_pkg::*;

  localparam int N  = 4;
  localparam int SW = 12;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sw_affine_array_if #(.PE_NUM(N), .SCORE_W(SW)) bus ();

  sw_affine_array #(.PE_NUM(N), .SCORE_W(SW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string name;
    string s;
    string t;
    int    match;
    int    mismatch;
    int    open;
    int    ext;
    int    exp_max;
    int    exp_row;
    int    exp_col;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic base_t enc(input string str, input int i);
    case (str[i])
      "A":     return BASE_A;
      "C":     return BASE_C;
      "G":     return BASE_G;
      default: return BASE_T;
    endcase
  endfunction

  // Present N beats; config is valid only on beat 0 and scrambled afterwards.
  task automatic feed(input string s, input string t, input int m, input int mm, input int go, input int ge);
    for (int i = 0; i < N; i++) begin
      bus.in_valid = 1'b1;
      bus.data_s   = enc(s, i);
      bus.data_t   = enc(t, i);
      if (i == 0) begin
        bus.cfg_match    = SW'(m);
        bus.cfg_mismatch = SW'(mm);
        bus.cfg_gap_open = SW'(go);
        bus.cfg_gap_ext  = SW'(ge);
      end else begin
        bus.cfg_match    = SW'(1);
        bus.cfg_mismatch = SW'(1);
        bus.cfg_gap_open = SW'(1);
        bus.cfg_gap_ext  = SW'(1);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  // Returns the cycle (beat 0 = cycle 0) in which out_valid is first seen high.
  task automatic wait_result(output int cyc, output int got);
    cyc = N - 1;
    while (!bus.out_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    got = int'(bus.out_valid);
    cyc = cyc + 1;
  endtask

  task automatic take_result(input string name);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({name, "_ov_drop"}, int'(bus.out_valid), 0);
    check({name, "_ir_back"}, int'(bus.in_ready), 1);
    check({name, "_max_clr"}, int'(bus.max), 0);
  endtask

  task automatic run_and_check(input string name, input string s, input string t, input int exp_max);
    int cyc, got;
    feed(s, t, DEF_MATCH, DEF_MISMATCH, DEF_GAP_OPEN, DEF_GAP_EXT);
    wait_result(cyc, got);
    check({name, "_valid"}, got, 1);
    check({name, "_max"}, int'(bus.max), exp_max);
    take_result(name);
  endtask

  initial begin
    int cyc, got, seen, held;

    vecs[0] = '{"full",  "ACGT", "ACGT",  8,  -5, -7, -3, 32, 3, 3};
    vecs[1] = '{"mism",  "AAAA", "CCCC",  8,  -5, -7, -3,  0, 0, 0};
    vecs[2] = '{"m2",    "AAAA", "AAAA",  2,  -5, -7, -3,  8, 3, 3};
    vecs[3] = '{"m8",    "AAAA", "AAAA",  8,  -5, -7, -3, 32, 3, 3};
    vecs[4] = '{"tie",   "ACGT", "TTTT",  8,  -5, -7, -3,  8, 3, 0};
    vecs[5] = '{"gap_f", "ACGT", "ACTT",  8, -20, -7, -3, 17, 3, 2};
    vecs[6] = '{"gap_e", "ACTT", "ACGT",  8, -20, -7, -3, 17, 2, 3};
    vecs[7] = '{"mixed", "ACGT", "AGTT",  8,  -5, -7, -3, 17, 3, 2};

    reset            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.out_ready    = 1'b0;
    bus.data_s       = '0;
    bus.data_t       = '0;
    bus.cfg_match    = '0;
    bus.cfg_mismatch = '0;
    bus.cfg_gap_open = '0;
    bus.cfg_gap_ext  = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 1);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_max", int'(bus.max), 0);
`ifdef SW_POS_TRACK_EN
    check("rst_row", int'(bus.out_row), 0);
    check("rst_col", int'(bus.out_col), 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      feed(vecs[i].s, vecs[i].t, vecs[i].match, vecs[i].mismatch, vecs[i].open, vecs[i].ext);
      wait_result(cyc, got);
      check({vecs[i].name, "_valid"}, got, 1);
      check({vecs[i].name, "_cycle"}, cyc, 2 * N - 1);
      check({vecs[i].name, "_max"}, int'(bus.max), vecs[i].exp_max);
`ifdef SW_POS_TRACK_EN
      check({vecs[i].name, "_row"}, int'(bus.out_row), vecs[i].exp_row);
      check({vecs[i].name, "_col"}, int'(bus.out_col), vecs[i].exp_col);
`endif
      take_result(vecs[i].name);
    end

    // Output backpressure: result held for 10 cycles, then released.
    feed("ACGT", "ACGT", DEF_MATCH, DEF_MISMATCH, DEF_GAP_OPEN, DEF_GAP_EXT);
    wait_result(cyc, got);
    check("bp_valid", got, 1);
    held = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.max !== SW'(32) || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) held = 0;
    end
    check("bp_hold_stable", held, 1);
    check("bp_max", int'(bus.max), 32);
    take_result("bp");

    // Abort: in_valid drops on beat 2, no result may appear.
    bus.in_valid     = 1'b1;
    bus.data_s       = BASE_A;
    bus.data_t       = BASE_A;
    bus.cfg_match    = SW'(DEF_MATCH);
    bus.cfg_mismatch = SW'(DEF_MISMATCH);
    bus.cfg_gap_open = SW'(DEF_GAP_OPEN);
    bus.cfg_gap_ext  = SW'(DEF_GAP_EXT);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("abort_no_valid", seen, 0);
    check("abort_in_ready", int'(bus.in_ready), 1);
    run_and_check("after_abort", "ACGT", "ACGT", 32);

    // Reset asserted in cycle 5 (mid-DRAIN).
    feed("ACGT", "ACGT", DEF_MATCH, DEF_MISMATCH, DEF_GAP_OPEN, DEF_GAP_EXT);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rdr_in_ready", int'(bus.in_ready), 1);
    check("rdr_out_valid", int'(bus.out_valid), 0);
    check("rdr_max", int'(bus.max), 0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    check("rdr_no_valid", seen, 0);
    run_and_check("after_rst", "ACGT", "ACGT", 32);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
